// File: rtl/wb_master_ctl_if.sv
// Command, response and strobe/ack bus signals of the wb_master_ctl initiator.
// master: the initiator side. slave: the host/peripheral side that faces it.
interface wb_master_ctl_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic          we_o;
    logic          stb_o;
    logic          cyc_o;
    logic          ack_i;
    logic [DW-1:0] dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, ack_i, dat_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
               adr_o, dat_o, we_o, stb_o, cyc_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, ack_i, dat_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
               adr_o, dat_o, we_o, stb_o, cyc_o
    );
endinterface

// File: rtl/wb_master_ctl.sv
// Single-outstanding initiator for the DDK 8-bit strobe/ack bus.
// Define WB_MASTER_TIMEOUT_EN to abort bus cycles that see no ack within TIMEOUT edges.
module wb_master_ctl #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    wb_master_ctl_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_dat_q, rsp_dat_d;
    logic          rsp_err_q, rsp_err_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          we_q, we_d;
    logic          stb_q, stb_d;
    logic          cyc_q, cyc_d;
    logic          timeout_s;

`ifdef WB_MASTER_TIMEOUT_EN
    logic [TW-1:0] cnt_q, cnt_d;
    // Limit is hit when this no-ack edge would bring the count up to TIMEOUT.
    assign timeout_s = (cnt_q == TW'(TIMEOUT - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output computation for the IDLE/BUS/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        stb_d       = stb_q;
        cyc_d       = cyc_q;
`ifdef WB_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    adr_d       = bus.cmd_adr;
                    dat_d       = bus.cmd_dat;
                    we_d        = bus.cmd_we;
                    stb_d       = 1'b1;
                    cyc_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_BUS;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            ST_BUS: begin
                if (bus.ack_i) begin
                    stb_d       = 1'b0;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_dat_d   = we_q ? {DW{1'b0}} : bus.dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_d       = {TW{1'b0}};
`endif
                    state_d     = ST_RESP;
                end else if (timeout_s) begin
                    stb_d       = 1'b0;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_dat_d   = {DW{1'b0}};
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_d       = {TW{1'b0}};
`endif
                    state_d     = ST_RESP;
                end else begin
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_d       = cnt_q + TW'(1);
`endif
                    state_d     = ST_BUS;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b0;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                stb_d       = 1'b0;
                cyc_d       = 1'b0;
                we_d        = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any cycle in flight without a response.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= {DW{1'b0}};
            rsp_err_q   <= 1'b0;
            adr_q       <= {AW{1'b0}};
            dat_q       <= {DW{1'b0}};
            we_q        <= 1'b0;
            stb_q       <= 1'b0;
            cyc_q       <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q       <= {TW{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            stb_q       <= stb_d;
            cyc_q       <= cyc_d;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.adr_o     = adr_q;
    assign bus.dat_o     = dat_q;
    assign bus.we_o      = we_q;
    assign bus.stb_o     = stb_q;
    assign bus.cyc_o     = cyc_q;
endmodule

// File: tb/tb_wb_master_ctl.sv
// Directed bench for wb_master_ctl: expected responses are queued at command time
// and popped when the response handshake completes.
module tb_wb_master_ctl;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   total = 0;
    int   bad   = 0;

    typedef struct packed {
        logic [7:0] dat;
        logic       err;
    } rsp_t;
    rsp_t exp_q[$];

    wb_master_ctl_if #(.AW(8), .DW(8)) bus_if ();

    wb_master_ctl #(.AW(8), .DW(8), .TW(8), .TIMEOUT(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus_if.master)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog expired: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one command through the accept edge and check the bus cycle starts.
    task automatic issue(input logic we, input logic [7:0] adr, input logic [7:0] dat);
        chk("pre_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_we    = we;
        bus_if.cmd_adr   = adr;
        bus_if.cmd_dat   = dat;
        tick();
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_dat   = 8'h00;
        chk("acc_stb", 32'(bus_if.stb_o), 32'd1);
        chk("acc_cyc", 32'(bus_if.cyc_o), 32'd1);
        chk("acc_adr", 32'(bus_if.adr_o), 32'(adr));
        chk("acc_dat", 32'(bus_if.dat_o), 32'(dat));
        chk("acc_we",  32'(bus_if.we_o),  32'(we));
        chk("acc_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
    endtask

    // Pop the expected response, compare, then complete the response handshake.
    task automatic take_rsp(input string tag);
        rsp_t e;
        chk({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'd1);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_rsp_dat"}, 32'(bus_if.rsp_dat), 32'(e.dat));
            chk({tag, "_rsp_err"}, 32'(bus_if.rsp_err), 32'(e.err));
        end
        bus_if.rsp_ready = 1'b1;
        tick();
        bus_if.rsp_ready = 1'b0;
        chk({tag, "_rsp_done"}, 32'(bus_if.rsp_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(bus_if.cmd_ready), 32'd1);
    endtask

    initial begin
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_we    = 1'b0;
        bus_if.cmd_adr   = 8'h00;
        bus_if.cmd_dat   = 8'h00;
        bus_if.rsp_ready = 1'b0;
        bus_if.ack_i     = 1'b0;
        bus_if.dat_i     = 8'h00;

        // Reset values, then first edge after release raises cmd_ready.
        @(posedge clk_i);
        tick();
        chk("rst_stb", 32'(bus_if.stb_o), 32'd0);
        chk("rst_cyc", 32'(bus_if.cyc_o), 32'd0);
        chk("rst_we", 32'(bus_if.we_o), 32'd0);
        chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(bus_if.rsp_err), 32'd0);
        chk("rst_adr", 32'(bus_if.adr_o), 32'd0);
        chk("rst_dat", 32'(bus_if.dat_o), 32'd0);
        chk("rst_rsp_dat", 32'(bus_if.rsp_dat), 32'd0);
        rst_i = 1'b1;
        tick();

        // Write 0xA5 to 0x10, ack on the second bus edge.
        exp_q.push_back('{dat: 8'h00, err: 1'b0});
        issue(1'b1, 8'h10, 8'hA5);
        tick();
        chk("wr_stb2", 32'(bus_if.stb_o), 32'd1);
        chk("wr_we2", 32'(bus_if.we_o), 32'd1);
        chk("wr_adr2", 32'(bus_if.adr_o), 32'h10);
        chk("wr_dat2", 32'(bus_if.dat_o), 32'hA5);
        bus_if.ack_i = 1'b1;
        bus_if.dat_i = 8'h3F;
        tick();
        bus_if.ack_i = 1'b0;
        chk("wr_stb_end", 32'(bus_if.stb_o), 32'd0);
        chk("wr_cyc_end", 32'(bus_if.cyc_o), 32'd0);
        chk("wr_we_end", 32'(bus_if.we_o), 32'd0);
        take_rsp("wr");

        // Read 0x3C with immediate ack returning 0x5A.
        exp_q.push_back('{dat: 8'h5A, err: 1'b0});
        issue(1'b0, 8'h3C, 8'h00);
        bus_if.ack_i = 1'b1;
        bus_if.dat_i = 8'h5A;
        tick();
        bus_if.ack_i = 1'b0;
        bus_if.dat_i = 8'h00;
        chk("rd_stb_1cyc", 32'(bus_if.stb_o), 32'd0);
        chk("rd_we_low", 32'(bus_if.we_o), 32'd0);
        take_rsp("rd");

        // Read 0x77 with the response stalled 5 cycles; ack and cmd_valid there are ignored.
        exp_q.push_back('{dat: 8'h42, err: 1'b0});
        issue(1'b0, 8'h77, 8'h00);
        bus_if.ack_i = 1'b1;
        bus_if.dat_i = 8'h42;
        tick();
        bus_if.ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_if.cmd_valid = (i == 2);
            bus_if.cmd_adr   = 8'h99;
            bus_if.ack_i     = (i == 3);
            bus_if.dat_i     = 8'hEE;
            tick();
            chk("hold_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
            chk("hold_rsp_dat", 32'(bus_if.rsp_dat), 32'h42);
            chk("hold_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
            chk("hold_stb", 32'(bus_if.stb_o), 32'd0);
        end
        bus_if.cmd_valid = 1'b0;
        bus_if.ack_i     = 1'b0;
        chk("hold_adr_not_latched", 32'(bus_if.adr_o), 32'h77);
        take_rsp("hold");

        // Ack pulsed while idle: no cycle, no response, rsp_dat untouched.
        bus_if.ack_i = 1'b1;
        bus_if.dat_i = 8'hEE;
        tick();
        bus_if.ack_i = 1'b0;
        chk("idle_ack_stb", 32'(bus_if.stb_o), 32'd0);
        chk("idle_ack_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("idle_ack_rsp_dat", 32'(bus_if.rsp_dat), 32'h42);
        chk("idle_ack_ready", 32'(bus_if.cmd_ready), 32'd1);

`ifdef WB_MASTER_TIMEOUT_EN
        // No ack: abort after the 4th bus edge.
        exp_q.push_back('{dat: 8'h00, err: 1'b1});
        issue(1'b0, 8'h21, 8'h00);
        bus_if.dat_i = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_stb_wait", 32'(bus_if.stb_o), 32'd1);
        end
        tick();
        chk("to_stb_fall", 32'(bus_if.stb_o), 32'd0);
        chk("to_cyc_fall", 32'(bus_if.cyc_o), 32'd0);
        take_rsp("to");

        // Ack on the 4th edge wins over the limit.
        exp_q.push_back('{dat: 8'h6B, err: 1'b0});
        issue(1'b0, 8'h22, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_ack_wait", 32'(bus_if.stb_o), 32'd1);
        end
        bus_if.ack_i = 1'b1;
        bus_if.dat_i = 8'h6B;
        tick();
        bus_if.ack_i = 1'b0;
        chk("to_ack_stb", 32'(bus_if.stb_o), 32'd0);
        take_rsp("to_ack");
`else
        // Without the timeout the cycle waits indefinitely for ack.
        exp_q.push_back('{dat: 8'h6B, err: 1'b0});
        issue(1'b0, 8'h22, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("wait_stb", 32'(bus_if.stb_o), 32'd1);
        end
        chk("wait_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
        bus_if.ack_i = 1'b1;
        bus_if.dat_i = 8'h6B;
        tick();
        bus_if.ack_i = 1'b0;
        take_rsp("wait");
`endif

        // Reset mid-BUS: bus drops asynchronously, no response afterwards.
        issue(1'b1, 8'h20, 8'h11);
        tick();
        chk("mid_stb", 32'(bus_if.stb_o), 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_stb", 32'(bus_if.stb_o), 32'd0);
        chk("arst_cyc", 32'(bus_if.cyc_o), 32'd0);
        chk("arst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("arst_adr", 32'(bus_if.adr_o), 32'd0);
        @(posedge clk_i);
        tick();
        rst_i = 1'b1;
        chk("arst_ready_before_edge", 32'(bus_if.cmd_ready), 32'd0);
        tick();
        chk("arst_ready_after", 32'(bus_if.cmd_ready), 32'd1);
        chk("arst_no_rsp", 32'(bus_if.rsp_valid), 32'd0);

        // Normal traffic resumes after reset.
        exp_q.push_back('{dat: 8'h00, err: 1'b0});
        issue(1'b1, 8'hFF, 8'h55);
        bus_if.ack_i = 1'b1;
        tick();
        bus_if.ack_i = 1'b0;
        take_rsp("post_rst");
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
